// File: rtl/motor_enc_pkg.sv
// Shared types, default parameters and the Gray-code step decoder for the
// quadrature decoder block.
package motor_enc_pkg;

  localparam int CNT_WIDTH_DEF  = 32;
  localparam int FILT_LEN_DEF   = 4;
  localparam int VEL_PERIOD_DEF = 100000;

  typedef logic [1:0] quad_t;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_INC,
    STEP_DEC,
    STEP_ERR
  } step_t;

  // {A,B}: 00 -> 01 -> 11 -> 10 -> 00 is forward; a double-bit change is illegal.
  function automatic step_t quad_decode(input quad_t prev, input quad_t cur);
    step_t s;
    s = STEP_NONE;
    case ({prev, cur})
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: s = STEP_INC;
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: s = STEP_DEC;
      4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: s = STEP_ERR;
      default:                                s = STEP_NONE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/enc_input_filter.sv
// Two-flop synchronizer plus debounce for one raw encoder channel. valid rises
// once the first stable level after reset has been captured.
module enc_input_filter
  import motor_enc_pkg::*;
#(
  parameter int FILT_LEN = FILT_LEN_DEF
) (
  input  logic clk_sys,
  input  logic rst_b,
  input  logic raw,
  output logic level,
  output logic valid
);

  localparam logic [3:0] CNT_TC = 4'(FILT_LEN - 1);

  logic       sync1;
  logic       sync2;
  logic [3:0] cnt;

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Before valid, level follows the synchronized input freely and valid waits
  // for a stable run; afterwards level moves only after a full stable run.
  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      level <= 1'b0;
      valid <= 1'b0;
      cnt   <= 4'd0;
    end else if (!valid) begin
      if (sync2 != level) begin
        level <= sync2;
        cnt   <= 4'd0;
      end else if (cnt == CNT_TC) begin
        valid <= 1'b1;
        cnt   <= 4'd0;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end else begin
      if (sync2 == level) begin
        cnt <= 4'd0;
      end else if (cnt == CNT_TC) begin
        level <= sync2;
        cnt   <= 4'd0;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/motor_quadrature_decoder.sv
// Quadrature decoder: filtered A/B channels drive a position counter, an
// error counter and a windowed velocity measurement. Define MOTOR_ENC_INDEX_EN
// to add the enc_i index input, whose filtered rising edge zeroes the position.
//
// quad state {A,B} | meaning
// 00               | phase 0
// 01               | phase 1 (forward from 00)
// 11               | phase 2
// 10               | phase 3
module motor_quadrature_decoder
  import motor_enc_pkg::*;
#(
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
  parameter int FILT_LEN   = FILT_LEN_DEF,
  parameter int VEL_PERIOD = VEL_PERIOD_DEF
) (
  input  logic                 S_AXI_ACLK,
  input  logic                 S_AXI_ARESETN,
  input  logic                 enc_a,
  input  logic                 enc_b,
`ifdef MOTOR_ENC_INDEX_EN
  input  logic                 enc_i,
`endif
  input  logic                 enable,
  input  logic                 clr_pos,
  output logic [CNT_WIDTH-1:0] position,
  output logic [CNT_WIDTH-1:0] velocity,
  output logic                 vel_valid,
  output logic                 dir,
  output logic [15:0]          err_cnt
);

  localparam int                   WIN_W  = (VEL_PERIOD > 2) ? $clog2(VEL_PERIOD) : 1;
  localparam logic [WIN_W-1:0]     WIN_TC = WIN_W'(VEL_PERIOD - 1);
  localparam logic [CNT_WIDTH-1:0] ONE    = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] SMAX   = {1'b0, {(CNT_WIDTH-1){1'b1}}};
  localparam logic [CNT_WIDTH-1:0] SMIN   = {1'b1, {(CNT_WIDTH-1){1'b0}}};

  logic a_lvl, a_vld, b_lvl, b_vld;

  enc_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
    .clk_sys(S_AXI_ACLK), .rst_b(S_AXI_ARESETN), .raw(enc_a), .level(a_lvl), .valid(a_vld)
  );

  enc_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
    .clk_sys(S_AXI_ACLK), .rst_b(S_AXI_ARESETN), .raw(enc_b), .level(b_lvl), .valid(b_vld)
  );

  quad_t cur;
  quad_t prev_q;
  logic  primed;
  step_t step_q;

  assign cur = {a_lvl, b_lvl};

  // The first valid sample only seeds prev_q, so no step follows reset.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      prev_q <= 2'b00;
      primed <= 1'b0;
      step_q <= STEP_NONE;
    end else begin
      step_q <= STEP_NONE;
      if (a_vld && b_vld) begin
        prev_q <= cur;
        primed <= 1'b1;
        if (primed) step_q <= quad_decode(prev_q, cur);
      end
    end
  end

  logic pos_clr;

`ifdef MOTOR_ENC_INDEX_EN
  logic i_lvl, i_vld, i_prev, i_primed, idx_q;

  enc_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_i (
    .clk_sys(S_AXI_ACLK), .rst_b(S_AXI_ARESETN), .raw(enc_i), .level(i_lvl), .valid(i_vld)
  );

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      i_prev   <= 1'b0;
      i_primed <= 1'b0;
      idx_q    <= 1'b0;
    end else begin
      idx_q <= 1'b0;
      if (i_vld) begin
        i_prev   <= i_lvl;
        i_primed <= 1'b1;
        idx_q    <= i_primed & i_lvl & ~i_prev;
      end
    end
  end

  assign pos_clr = clr_pos | idx_q;
`else
  assign pos_clr = clr_pos;
`endif

  logic step_mv;
  logic step_up;

  assign step_mv = enable && ((step_q == STEP_INC) || (step_q == STEP_DEC));
  assign step_up = (step_q == STEP_INC);

  logic [CNT_WIDTH-1:0] pos_q;
  logic                 dir_q;
  logic [15:0]          err_q;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      pos_q <= '0;
      dir_q <= 1'b0;
      err_q <= 16'd0;
    end else begin
      if (pos_clr) begin
        pos_q <= '0;
      end else if (step_mv) begin
        pos_q <= step_up ? pos_q + ONE : pos_q - ONE;
        dir_q <= step_up;
      end
      if ((step_q == STEP_ERR) && (err_q != 16'hFFFF)) err_q <= err_q + 16'd1;
    end
  end

  logic [WIN_W-1:0]     win_cnt;
  logic                 win_tc;
  logic [CNT_WIDTH-1:0] acc_q;
  logic [CNT_WIDTH-1:0] acc_base;
  logic [CNT_WIDTH-1:0] acc_next;
  logic [CNT_WIDTH-1:0] vel_q;
  logic                 vel_vld_q;

  assign win_tc = (win_cnt == WIN_TC);

  // A step on the terminal cycle lands in the freshly restarted window.
  always_comb begin
    acc_base = win_tc ? '0 : acc_q;
    acc_next = acc_base;
    if (step_mv) begin
      if (step_up) acc_next = (acc_base == SMAX) ? SMAX : acc_base + ONE;
      else         acc_next = (acc_base == SMIN) ? SMIN : acc_base - ONE;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      win_cnt   <= '0;
      acc_q     <= '0;
      vel_q     <= '0;
      vel_vld_q <= 1'b0;
    end else begin
      win_cnt   <= win_tc ? '0 : win_cnt + 1'b1;
      acc_q     <= acc_next;
      vel_vld_q <= win_tc;
      if (win_tc) vel_q <= acc_q;
    end
  end

  assign position  = pos_q;
  assign velocity  = vel_q;
  assign vel_valid = vel_vld_q;
  assign dir       = dir_q;
  assign err_cnt   = err_q;

endmodule
